// File: rtl/apb_req_arbiter_if.sv
// APB bus between the request arbiter (master) and the shared register-file slave.
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that sequences single-beat register requests onto one APB slave,
// with a PREADY watchdog that aborts a stuck ACCESS phase.
//
// state  | meaning
// IDLE   | arbitrating; also the cycle in which the previous ack is presented
// SETUP  | PSEL high, PENABLE low, bus payload captured
// ACCESS | PSEL and PENABLE high, waiting on PREADY or watchdog expiry
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  apb_req_arbiter_if.master           apb
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GID_W-1:0] GID_MAX = GID_W'(NUM_REQ - 1);
  localparam logic [GID_W:0]   NREQ_X  = (GID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GID_W-1:0]    ptr_q, ptr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                busy_q, busy_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  mask;
  logic                found;
  logic [GID_W-1:0]    pick;

  // Requester acked in this cycle is masked so it cannot be re-granted on its own ack edge.
  always_comb begin
    logic [GID_W:0] idx;
    mask  = req & ~ack_q;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (GID_W + 1)'(i);
      if (idx >= NREQ_X) begin
        idx = idx - NREQ_X;
      end
      if (!found && mask[idx[GID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[GID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    busy_d    = busy_q;
    gid_d     = gid_q;
    ack_d     = '0;
    rdata_d   = '0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_SETUP;
          gid_d     = pick;
          paddr_d   = req_addr[pick*ADDR_W +: ADDR_W];
          pwdata_d  = req_wdata[pick*DATA_W +: DATA_W];
          pwrite_d  = req_write[pick];
          ptr_d     = (pick == GID_MAX) ? '0 : pick + 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wd_d      = '0;
      end

      ST_ACCESS: begin
        if (apb.PREADY) begin
          state_d      = ST_IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          busy_d       = 1'b0;
          ack_d[gid_q] = 1'b1;
          rdata_d      = pwrite_q ? '0 : apb.PRDATA;
          err_d        = apb.PSLVERR;
        end else begin
          wd_d = wd_q + 1'b1;
          // Watchdog: the TIMEOUT-th consecutive not-ready ACCESS cycle ends the transfer.
          if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
            state_d      = ST_IDLE;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            busy_d       = 1'b0;
            ack_d[gid_q] = 1'b1;
            rdata_d      = '0;
            err_d        = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      wd_q      <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      gid_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      gid_q     <= gid_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios then randomized traffic, all checked
// against a transaction-level model (grant order, wait count, completion data).
module tb_apb_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int GW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy;
  logic [GW-1:0]   grant_id;

  apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id), .apb(apb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: in-flight transfer described by edges elapsed since its grant
  bit            m_inflight;
  int            m_n, m_w, m_ptr, m_g;
  logic [N-1:0]  e_ack;
  logic [DW-1:0] e_rdata, e_pwdata;
  logic [AW-1:0] e_paddr;
  logic          e_err, e_psel, e_pen, e_busy, e_pwrite;
  int            e_gid;

  int            fixed_w;
  bit            fix_rd, fix_err;
  logic [DW-1:0] rd_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_slave();
    if (m_inflight && m_n >= 1) apb.PREADY = (m_n > m_w);
    else                        apb.PREADY = 1'($urandom_range(0, 1));
    apb.PRDATA  = fix_rd ? rd_val : $urandom;
    apb.PSLVERR = fix_rd ? fix_err : ($urandom_range(0, 3) == 0);
  endtask

  task automatic complete(input logic err, input logic [DW-1:0] rd);
    e_ack[m_g] = 1'b1;
    e_err      = err;
    e_rdata    = rd;
    e_psel     = 1'b0;
    e_pen      = 1'b0;
    e_busy     = 1'b0;
    m_inflight = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] mask;
    bit found;
    if (rst) begin
      m_inflight = 0; m_ptr = 0; e_gid = 0;
      e_ack = '0; e_rdata = '0; e_err = 0; e_psel = 0; e_pen = 0; e_busy = 0;
      e_paddr = '0; e_pwdata = '0; e_pwrite = 0;
    end else begin
      mask  = req & ~e_ack;
      e_ack = '0; e_rdata = '0; e_err = 0;
      if (!m_inflight) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && mask[(m_ptr + k) % N]) begin
            found = 1;
            m_g   = (m_ptr + k) % N;
          end
        end
        if (found) begin
          m_inflight = 1; m_n = 0;
          m_w = (fixed_w >= 0) ? fixed_w :
                (($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)));
          e_psel = 1; e_pen = 0; e_busy = 1;
          e_paddr  = req_addr[m_g*AW +: AW];
          e_pwdata = req_wdata[m_g*DW +: DW];
          e_pwrite = req_write[m_g];
          e_gid    = m_g;
          m_ptr    = (m_g + 1) % N;
        end
      end else if (m_n == 0) begin
        m_n = 1; e_pen = 1;
      end else if (apb.PREADY) begin
        complete(apb.PSLVERR, e_pwrite ? '0 : apb.PRDATA);
      end else if (TO != 0 && m_n == TO) begin
        complete(1'b1, '0);
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic cyc();
    drive_slave();
    model_edge();
    @(posedge clk);
    #1;
    chk("ack", ack, e_ack);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_err", rsp_err, e_err);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, e_gid[GW-1:0]);
    chk("psel", apb.PSEL, e_psel);
    chk("penable", apb.PENABLE, e_pen);
    chk("paddr", apb.PADDR, e_paddr);
    chk("pwdata", apb.PWDATA, e_pwdata);
    chk("pwrite", apb.PWRITE, e_pwrite);
  endtask

  task automatic run_until_ack(input int maxc, output int n, output int pen);
    n = 0; pen = 0;
    do begin
      cyc();
      n++;
      if (apb.PENABLE) pen++;
    end while (ack == '0 && n < maxc);
  endtask

  task automatic new_payload(input int i);
    req_write[i]         = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW] = AW'($urandom);
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  initial begin
    int n, pen;
    logic [N-1:0] ackv [12];
    int nacks;

    rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    e_ack = '0; e_rdata = '0; e_err = 0; e_psel = 0; e_pen = 0; e_busy = 0;
    e_paddr = '0; e_pwdata = '0; e_pwrite = 0; e_gid = 0;
    m_inflight = 0; m_n = 0; m_w = 0; m_ptr = 0; m_g = 0;
    fixed_w = 0; fix_rd = 0; fix_err = 0; rd_val = '0;

    // reset
    cyc(); cyc();
    chk("rst_psel", apb.PSEL, 1'b0);
    chk("rst_ack", ack, 2'b00);
    rst = 1'b0;
    cyc();

    // write, zero wait
    req = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 5'h04; req_wdata[0 +: DW] = 32'hA5A5_0001;
    cyc();
    chk("wr_t1_psel", apb.PSEL, 1'b1);
    chk("wr_t1_pen", apb.PENABLE, 1'b0);
    cyc();
    chk("wr_t2_pen", apb.PENABLE, 1'b1);
    chk("wr_t2_paddr", apb.PADDR, 5'h04);
    chk("wr_t2_pwdata", apb.PWDATA, 32'hA5A5_0001);
    cyc();
    chk("wr_t3_ack", ack, 2'b01);
    chk("wr_t3_err", rsp_err, 1'b0);
    req = 2'b00;
    cyc();

    // read, two wait states
    fixed_w = 2; fix_rd = 1; fix_err = 0; rd_val = 32'h1234_5678;
    req = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 5'h08;
    run_until_ack(12, n, pen);
    chk("rd_lat", n, 5);
    chk("rd_pen_cycles", pen, 3);
    chk("rd_ack", ack, 2'b10);
    chk("rd_data", rsp_rdata, 32'h1234_5678);
    req = 2'b00;
    cyc();

    // contention, both requesters held
    fixed_w = 0; fix_rd = 0;
    req = 2'b11;
    nacks = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      ackv[c] = ack;
      if (ack != '0) nacks++;
    end
    chk("rr_ack_t3", ackv[2], 2'b01);
    chk("rr_ack_t6", ackv[5], 2'b10);
    chk("rr_ack_t9", ackv[8], 2'b01);
    chk("rr_ack_t12", ackv[11], 2'b10);
    chk("rr_ack_count", nacks, 4);
    req = 2'b00;
    cyc(); cyc(); cyc();

    // slave error, then clean transfer
    fix_rd = 1; fix_err = 1; rd_val = 32'hDEAD_0042;
    req = 2'b01; req_write = 2'b00;
    run_until_ack(12, n, pen);
    chk("err_ack", ack, 2'b01);
    chk("err_flag", rsp_err, 1'b1);
    chk("err_rdata", rsp_rdata, 32'hDEAD_0042);
    req = 2'b00;
    cyc();
    chk("err_ack_once", ack, 2'b00);
    fix_err = 0;
    req = 2'b10; req_write = 2'b00;
    run_until_ack(12, n, pen);
    chk("err_clear", rsp_err, 1'b0);
    req = 2'b00;
    cyc();

    // watchdog timeout
    fixed_w = 1000; fix_rd = 0;
    req = 2'b01; req_write = 2'b00;
    run_until_ack(40, n, pen);
    chk("to_lat", n, 18);
    chk("to_pen_cycles", pen, 16);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_psel", apb.PSEL, 1'b0);
    req = 2'b00;
    cyc();

    // reset mid-ACCESS
    req = 2'b01;
    cyc(); cyc(); cyc(); cyc();
    chk("mid_pen", apb.PENABLE, 1'b1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_psel", apb.PSEL, 1'b0);
    chk("mid_rst_pen", apb.PENABLE, 1'b0);
    chk("mid_rst_ack", ack, 2'b00);
    rst = 1'b0; fixed_w = 0; req = 2'b11;
    cyc();
    chk("post_rst_gid", grant_id, 1'b0);
    chk("post_rst_psel", apb.PSEL, 1'b1);
    req = 2'b00;
    for (int c = 0; c < 4; c++) cyc();

    // randomized traffic
    fixed_w = -1; fix_rd = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (e_ack[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            new_payload(i);
          end else if ($urandom_range(0, 29) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          new_payload(i);
        end
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB slave port (the SPI controller register file) among NUM_REQ requesters (CPU model, DMA model, test sequencer).
- Each requester issues simple single-beat register requests. The block grants one request, drives the APB SETUP/ACCESS protocol, waits on PREADY, and returns read data and error status with a one-cycle ack.
- Includes a PREADY watchdog so a hung slave cannot lock the bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 5, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held with payload until its ack.
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_W  read data, valid with ack.
- rsp_err  out  1  PSLVERR or timeout, valid with ack.
- busy  out  1  high in SETUP/ACCESS.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - State IDLE; all outputs 0 (PSEL, PENABLE, PADDR, PWDATA, PWRITE, ack, rsp_rdata, rsp_err, busy, grant_id).
  - Round-robin pointer = 0; watchdog counter = 0.
  - Reset mid-transfer drops PSEL/PENABLE on that edge with no ack.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - Arbitration mask = req & ~ack, so the requester acked this cycle is excluded.
  - If the mask is nonzero, grant the first set bit searching upward from the pointer with wrap (pointer..NUM_REQ-1, then 0..pointer-1).
  - On grant: capture addr/wdata/write into PADDR/PWDATA/PWRITE, set grant_id, set pointer = grant+1 mod NUM_REQ, go to SETUP.
  - SETUP outputs on the next edge: PSEL=1, PENABLE=0, busy=1.
- SETUP: unconditionally go to ACCESS with PENABLE=1 and the watchdog cleared.
- ACCESS, PREADY=1 at the edge:
  - Go to IDLE; PSEL=0, PENABLE=0, busy=0.
  - ack[grant_id]=1 for exactly one cycle.
  - rsp_rdata = PRDATA for reads, 0 for writes; rsp_err = PSLVERR.
- ACCESS, PREADY=0:
  - Watchdog increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 on this edge: abort to IDLE with ack, rsp_err=1, rsp_rdata=0.
- Bus stability:
  - PADDR/PWDATA/PWRITE stay stable from SETUP through completion.
  - They hold their last value in IDLE (no return to 0).
- Timing:
  - Zero-wait latency: req seen in IDLE at edge T0 → PSEL at T1 → PENABLE at T2 → ack at T3.
  - Back-to-back transfers complete every 3 cycles.
  - The ack cycle is itself an IDLE arbitration cycle.
- req deassertion:
  - Dropped before grant: ignored.
  - Dropped after grant: the transaction still completes and acks.
- Simultaneous events:
  - All requests asserted → strict round-robin order 0,1,…,NUM_REQ-1,0.
  - A single persistent requester gets a grant every 3 cycles (mask only blocks the ack cycle).
- ack and rsp_* are 0 on all non-completion cycles.

Test Plan:
- Write, zero wait: req[0]=1, write=1, addr=0x04, wdata=0xA5A5_0001 → PSEL at T1, PENABLE at T2; PADDR=0x04, PWDATA=0xA5A5_0001 held; ack=2'b01 at T3, rsp_err=0.
- Read, 2 wait states: req[1] read addr=0x08, PREADY low 2 ACCESS cycles, PRDATA=0x1234_5678 → ack=2'b10 at T5, rsp_rdata=0x1234_5678, PENABLE high 3 cycles.
- Contention: req=2'b11 held continuously, zero-wait → grants 0,1,0,1; acks at T3,T6,T9,T12; no double grant.
- Slave error: read with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_rdata=PRDATA, ack pulses once; next transfer rsp_err=0.
- Timeout: TIMEOUT=16, PREADY stuck 0 → abort after 16 ACCESS cycles; ack with rsp_err=1, rsp_rdata=0; PSEL=0 on the same edge.
- Reset mid-ACCESS: rst=1 during a waited read → next edge PSEL=PENABLE=0, ack never pulses; after release, req=2'b11 grants requester 0 first.
